pulse_stretcher: RTL and testbench

- Converts single-cycle event strobes (e.g. the output of an edge detector) back into level windows of fixed, guaranteed duration.
- Each accepted strobe produces exactly one active window of high_cycles_p cycles, followed by a mandatory inactive gap of gap_cycles_p cycles.
- Strobes that arrive while a window or gap is in progress are queued in a saturating pending counter and replayed in order.
- Sits between event sources and slow consumers such as LEDs, external enables and handshake lines.

---
 rtl/pulse_stretcher.sv | 136 +++++++++++++
 tb/tb_pulse_stretcher.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event strobes into fixed-length level
// windows, each followed by a mandatory inactive gap. Strobes that arrive while
// a window or gap is running are queued in a saturating counter and replayed.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no window in progress, queue empty, level_o inactive
//   HIGH  | active window, r_cnt counts 0 .. high_cycles_p-1
//   GAP   | inactive gap, r_cnt counts 0 .. gap_cycles_p-1; the last gap
//         | cycle either replays a queued strobe, starts a window directly
//         | from a fresh strobe, or falls back to IDLE
module pulse_stretcher #(
  parameter int unsigned high_cycles_p = 4,
  parameter int unsigned gap_cycles_p  = 2,
  parameter int unsigned max_pending_p = 3,
  parameter int unsigned cnt_width_p   = 8,
  parameter logic        active_high_p = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic                                 pulse_i,
  output logic                                 level_o,
  output logic                                 busy_o,
  output logic [$clog2(max_pending_p+1)-1:0]   pending_o,
  output logic                                 drop_o
);

  localparam int unsigned PendW = $clog2(max_pending_p + 1);

  // Terminal counts: the counter runs up from 0 and stops at parameter-1.
  localparam logic [cnt_width_p-1:0] HighLast = cnt_width_p'(high_cycles_p - 1);
  localparam logic [cnt_width_p-1:0] GapLast  = cnt_width_p'(gap_cycles_p - 1);
  localparam logic [PendW-1:0]       PendMax  = PendW'(max_pending_p);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [cnt_width_p-1:0] r_cnt;
  logic [PendW-1:0]       r_pend;

  logic             w_high_done;
  logic             w_gap_done;
  logic             w_consume;
  logic             w_direct;
  logic             w_queue_req;
  logic             w_accept;
  logic             w_drop;
  logic [PendW-1:0] w_pend_nxt;

  assign w_high_done = (r_state == HIGH) && (r_cnt == HighLast);
  assign w_gap_done  = (r_state == GAP)  && (r_cnt == GapLast);

  // Last gap cycle with work queued: the oldest queued strobe starts the next window.
  assign w_consume   = w_gap_done && (r_pend != '0);

  // Last gap cycle with an empty queue: a fresh strobe starts a window straight away.
  assign w_direct    = w_gap_done && (r_pend == '0) && pulse_i;

  // Any other strobe outside IDLE has to go through the queue.
  assign w_queue_req = pulse_i && (r_state != IDLE) && !w_direct;

  // A slot freed by a same-cycle consume makes room even when the queue is full.
  assign w_accept    = w_queue_req && ((r_pend != PendMax) || w_consume);
  assign w_drop      = w_queue_req && !w_accept;

  assign pending_o   = r_pend;

  // Next queue depth: accept and consume in the same cycle cancel out.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_accept && !w_consume) begin
      w_pend_nxt = r_pend + 1'b1;
    end else if (!w_accept && w_consume) begin
      w_pend_nxt = r_pend - 1'b1;
    end
  end

  // Window/gap sequencer with registered outputs; reset aborts everything with no replay.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      drop_o  <= 1'b0;
      busy_o  <= 1'b0;
      level_o <= ~active_high_p;
    end else begin
      r_pend <= w_pend_nxt;
      drop_o <= w_drop;
      case (r_state)
        IDLE: begin
          if (pulse_i) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            level_o <= active_high_p;
            busy_o  <= 1'b1;
          end
        end
        HIGH: begin
          if (w_high_done) begin
            r_state <= GAP;
            r_cnt   <= '0;
            level_o <= ~active_high_p;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (w_gap_done) begin
            r_cnt <= '0;
            if (w_consume || w_direct) begin
              r_state <= HIGH;
              level_o <= active_high_p;
            end else begin
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          level_o <= ~active_high_p;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher. Two instances share the stimulus: one
// with active-high output, one with active-low output whose level must always
// be the inverse. Each scenario is written as per-cycle strings: character i
// of the pulse/reset strings drives cycle 10+i, character i of the expected
// strings is the output seen in cycle 11+i (missing characters mean 0, or 1
// for reset).
module tb_pulse_stretcher;

  logic       clk_i;
  logic       reset_ni;
  logic       pulse_i;
  logic       level_o;
  logic       busy_o;
  logic [1:0] pending_o;
  logic       drop_o;
  logic       level_n_o;
  logic       busy_n_o;
  logic [1:0] pending_n_o;
  logic       drop_n_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pulse_stretcher dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .pulse_i   (pulse_i),
    .level_o   (level_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .drop_o    (drop_o)
  );

  pulse_stretcher #(.active_high_p(1'b0)) dut_n (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .pulse_i   (pulse_i),
    .level_o   (level_n_o),
    .busy_o    (busy_n_o),
    .pending_o (pending_n_o),
    .drop_o    (drop_n_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_bit(input string s, input int i);
    if (i < s.len() && s[i] == 8'h31) return 8'd1;
    return 8'd0;
  endfunction

  function automatic logic [7:0] exp_dig(input string s, input int i);
    if (i < s.len()) return 8'(s[i]) - 8'h30;
    return 8'd0;
  endfunction

  function automatic logic rst_bit(input string s, input int i);
    if (i < s.len() && s[i] == 8'h30) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk_outputs(input string name, input logic [7:0] e_lvl,
                             input logic [7:0] e_busy, input logic [7:0] e_pend,
                             input logic [7:0] e_drop);
    chk({name, ".level"},   {7'd0, level_o},   e_lvl);
    chk({name, ".level_n"}, {7'd0, level_n_o}, (e_lvl == 8'd1) ? 8'd0 : 8'd1);
    chk({name, ".busy"},    {7'd0, busy_o},    e_busy);
    chk({name, ".pending"}, {6'd0, pending_o}, e_pend);
    chk({name, ".drop"},    {7'd0, drop_o},    e_drop);
  endtask

  // Hold reset for three cycles with pulse_i toggling, then idle up to cycle 10.
  task automatic do_reset(input string name);
    reset_ni = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse_i = (k % 2 == 0);
      tick();
      chk_outputs({name, ".rst"}, 8'd0, 8'd0, 8'd0, 8'd0);
    end
    reset_ni = 1'b1;
    pulse_i  = 1'b0;
    cyc      = 1;
    while (cyc < 10) tick();
    chk_outputs({name, ".idle"}, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic run(input string name, input string p, input string r,
                     input string l, input string b, input string d,
                     input string x);
    do_reset(name);
    for (int i = 0; i < 26; i++) begin
      pulse_i  = exp_bit(p, i)[0];
      reset_ni = rst_bit(r, i);
      tick();
      chk_outputs(name, exp_bit(l, i), exp_bit(b, i), exp_dig(d, i), exp_bit(x, i));
    end
    reset_ni = 1'b1;
    pulse_i  = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0;
    pulse_i  = 1'b0;

    // Single strobe at cycle 10: window 11-14, gap 15-16, idle from 17.
    run("single", "1", "", "1111", "111111", "", "");

    // Strobes at 10 and 12: second one queued, replayed as window 17-20.
    run("queued", "101", "", "1111001111", "111111111111", "001111", "");

    // Strobes at 10, 12 and 16 (last gap cycle): consume and accept cancel,
    // windows back to back at 11-14, 17-20, 23-26.
    run("lastgap", "1010001", "", "1111001111001111",
        "111111111111111111", "001111111111", "");

    // Strobe held 10-14: queue saturates at 3, strobe 14 dropped, four windows.
    run("saturate", "11111", "", "1111001111001111001111",
        "111111111111111111111111", "012333222222111111", "00001");

    // Reset at cycle 13 with two strobes queued: everything aborts, no replay.
    run("abort", "111", "1110", "111", "111", "012", "");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
